// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operation encodings, FSM states and fixed divide results.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned DW   = 2 * XLEN;
    localparam int unsigned CNTW = 6;
    localparam int unsigned RW   = 5;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;
    localparam logic [CNTW-1:0] LAST_ITER  = 6'd31;

    function automatic logic op_is_div(input md_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic op_is_rem(input md_op_e op);
        return op inside {MD_REM, MD_REMU};
    endfunction

    function automatic logic op_a_signed(input md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic op_b_signed(input md_op_e op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement; used for operand magnitudes and the final sign fix-up.
module muldiv_negate #(
    parameter int unsigned W = 64
) (
    input  logic         en_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] val_c_o
);

    always_comb begin
        val_c_o = en_i ? (~val_i + W'(1)) : val_i;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply and restoring
// divide on magnitudes, sign fix-up in FIX, with a one-cycle divide fast path.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            areset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [RW-1:0]   rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [RW-1:0]   rd_out,
    output logic            we_out
);

    md_state_e       state_q, state_d;
    md_op_e          op_in_c, op_q, op_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic [DW-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [XLEN-1:0] mplr_q, mplr_d, result_q, result_d;
    logic [RW-1:0]   rd_q, rd_d;
    logic            busy_q, busy_d, done_q, done_d, we_q, we_d;

    logic            neg_a_c, neg_b_c, div_zero_c, div_ovf_c, fast_c, trial_ge_c;
    logic [XLEN-1:0] mag_a_c, mag_b_c, fast_res_c, diff_c;
    logic [XLEN:0]   trial_c;
    logic [DW-1:0]   fix_in_c, fix_c;

    // Operand decode at acceptance time
    always_comb begin
        op_in_c    = md_op_e'(funct3);
        neg_a_c    = op_a_signed(op_in_c) & rs1_val[XLEN-1];
        neg_b_c    = op_b_signed(op_in_c) & rs2_val[XLEN-1];
        div_zero_c = (rs2_val == '0);
        div_ovf_c  = op_b_signed(op_in_c) && (rs1_val == INT_MIN) && (rs2_val == '1);
        fast_c     = op_is_div(op_in_c) && (div_zero_c || div_ovf_c);
        if (div_zero_c) begin
            fast_res_c = op_is_rem(op_in_c) ? rs1_val : DIV_ZERO_Q;
        end else begin
            fast_res_c = op_is_rem(op_in_c) ? '0 : INT_MIN;
        end
    end

    muldiv_negate #(.W(XLEN)) u_mag_a (.en_i(neg_a_c), .val_i(rs1_val), .val_c_o(mag_a_c));
    muldiv_negate #(.W(XLEN)) u_mag_b (.en_i(neg_b_c), .val_i(rs2_val), .val_c_o(mag_b_c));

    // Restoring divide step: remainder lives in acc[63:32], dividend/quotient in acc[31:0]
    always_comb begin
        trial_c    = acc_q[DW-1:XLEN-1];
        trial_ge_c = (trial_c >= {1'b0, mcand_q[XLEN-1:0]});
        diff_c     = trial_c[XLEN-1:0] - mcand_q[XLEN-1:0];
    end

    always_comb begin
        if (!op_is_div(op_q)) begin
            fix_in_c = acc_q;
        end else if (op_is_rem(op_q)) begin
            fix_in_c = {{XLEN{1'b0}}, acc_q[DW-1:XLEN]};
        end else begin
            fix_in_c = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
        end
    end

    muldiv_negate #(.W(DW)) u_fix (.en_i(sign_q), .val_i(fix_in_c), .val_c_o(fix_c));

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = fast_c ? ST_DONE : ST_ITER;
            ST_ITER: if (cnt_q == LAST_ITER) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d     = op_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = op_in_c;
                    rd_d   = rd_addr;
                    cnt_d  = '0;
                    sign_d = op_is_rem(op_in_c) ? neg_a_c : (neg_a_c ^ neg_b_c);
                    mplr_d = mag_b_c;
                    if (op_is_div(op_in_c)) begin
                        acc_d   = {{XLEN{1'b0}}, mag_a_c};
                        mcand_d = {{XLEN{1'b0}}, mag_b_c};
                    end else begin
                        acc_d   = '0;
                        mcand_d = {{XLEN{1'b0}}, mag_a_c};
                    end
                    if (fast_c) result_d = fast_res_c;
                end
            end
            ST_ITER: begin
                cnt_d = cnt_q + CNTW'(1);
                if (op_is_div(op_q)) begin
                    acc_d = trial_ge_c ? {diff_c, acc_q[XLEN-2:0], 1'b1}
                                       : {trial_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end else begin
                    if (mplr_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d = {mcand_q[DW-2:0], 1'b0};
                    mplr_d  = {1'b0, mplr_q[XLEN-1:1]};
                end
            end
            ST_FIX: begin
                if (op_q inside {MD_MULH, MD_MULHSU, MD_MULHU}) begin
                    result_d = fix_c[DW-1:XLEN];
                end else begin
                    result_d = fix_c[XLEN-1:0];
                end
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        we_d   = done_d && (rd_d != '0);
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            op_q     <= MD_MUL;
            rd_q     <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            op_q     <= op_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_q;
    assign we_out = we_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results and latencies.
module tb_muldiv_unit;

    logic        clk;
    logic        areset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we_out;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit dut (
        .clk     (clk),
        .areset  (areset),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out),
        .we_out  (we_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation, scramble operands after acceptance, wait for done.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        funct3  = op;
        rs1_val = a;
        rs2_val = b;
        rd_addr = rd;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        rs1_val = 32'h1234_5678;
        rs2_val = 32'h0000_0003;
        rd_addr = 5'd31;
        funct3  = 3'd2;
        lat = 1;
        while (!done && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp_res);
        check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
        check({tag, " we_out"}, 32'(we_out), 32'(rd != 5'd0));
        check({tag, " busy@done"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int n_done;
        int done_lat;
        areset  = 1'b1;
        start   = 1'b0;
        funct3  = 3'd0;
        rs1_val = '0;
        rs2_val = '0;
        rd_addr = '0;
        #3 areset = 1'b0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", 32'(rd_out), 32'd0);
        check("reset we_out", 32'(we_out), 32'd0);
        @(negedge clk) areset = 1'b1;
        @(posedge clk); #1;

        run_op("MUL 7*-3",      3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34);
        run_op("MULHU -1*-1",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 34);
        run_op("MULH -1*-1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 34);
        run_op("MULHSU -1*-1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 34);
        run_op("DIV -7/2",      3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD, 34);
        run_op("REM -7/2",      3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 34);
        run_op("DIVU 100/7",    3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        34);
        run_op("REMU 100/7",    3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         34);
        run_op("DIVU big/max",  3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'd0,         34);
        run_op("DIV 5/0",       3'd4, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF, 1);
        run_op("REM 5/0",       3'd6, 32'd5,         32'd0,         5'd11, 32'd5,         1);
        run_op("REMU 5/0",      3'd7, 32'd5,         32'd0,         5'd12, 32'd5,         1);
        run_op("DIV ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
        run_op("REM ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1);
        run_op("MUL rd0",       3'd0, 32'd3,         32'd4,         5'd0,  32'd12,        34);

        // A second start during a multiply must be ignored.
        funct3  = 3'd0;
        rs1_val = 32'd6;
        rs2_val = 32'd7;
        rd_addr = 5'd3;
        start   = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 1;
        n_done   = 0;
        done_lat = 0;
        repeat (44) begin
            start = (lat == 9);
            if (start) begin
                funct3  = 3'd5;
                rs1_val = 32'd100;
                rs2_val = 32'd0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (done) begin
                n_done++;
                done_lat = lat;
                check("busy-start result", result, 32'd42);
            end
        end
        check("busy-start done count", 32'(n_done), 32'd1);
        check("busy-start latency", 32'(done_lat), 32'd34);

        // Asynchronous reset in the middle of a divide.
        funct3  = 3'd4;
        rs1_val = 32'd1000;
        rs2_val = 32'd3;
        rd_addr = 5'd7;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1 areset = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", result, 32'd0);
        check("abort rd_out", 32'(rd_out), 32'd0);
        check("abort we_out", 32'(we_out), 32'd0);
        n_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        @(negedge clk) areset = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("abort no done", 32'(n_done), 32'd0);

        run_op("DIVU 9/3 after reset", 3'd5, 32'd9, 32'd3, 5'd15, 32'd3, 34);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
